axis_protocol_monitor: RTL and testbench
========================================

Name: axis_protocol_monitor

Overview:
- Synthesizable, parametrised AXI4-Stream protocol monitor for NUM_CH independent channels.
- Taps the openHMC TX/RX AXI ports passively; never drives TREADY/TVALID.
- Per-channel checks: valid-hold, TDATA/TUSER stability while stalled, stall timeout.
- Reports sticky error flags, saturating error/beat counters and a stall-duration maximum for RF readout.

Parameters:
- NUM_CH, 2, number of monitored AXI-stream channels (>=1).
- DWIDTH, 512, TDATA width per channel.
- UWIDTH, 64, TUSER width per channel.
- MAX_STALL, 1023, stall cycles (valid & !ready) before timeout error (>=2).
- CNT_W, 16, width of error and beat counters.
- STALL_W, $clog2(MAX_STALL+1), stall counter width (derived, leave untouched).

Ports:
- clk_hmc  in  1  monitor clock; all inputs sampled on rising edge.
- res_n_hmc  in  1  asynchronous active-low reset.
- tvalid  in  NUM_CH  per-channel TVALID.
- tready  in  NUM_CH  per-channel TREADY.
- tdata  in  NUM_CH*DWIDTH  channel c at [c*DWIDTH +: DWIDTH].
- tuser  in  NUM_CH*UWIDTH  channel c at [c*UWIDTH +: UWIDTH].
- clear  in  1  synchronous clear of all flags, counters and maxima.
- err_valid_drop  out  NUM_CH  sticky: TVALID deasserted while stalled.
- err_payload_change  out  NUM_CH  sticky: TDATA or TUSER changed while stalled.
- err_timeout  out  NUM_CH  sticky: stall reached MAX_STALL.
- err_any  out  1  OR of all sticky flags.
- err_count  out  NUM_CH*CNT_W  total error events per channel, saturating.
- beat_count  out  NUM_CH*CNT_W  accepted beats (valid & ready), saturating.
- stall_max  out  NUM_CH*STALL_W  longest stall observed, saturates at MAX_STALL.

Behaviour:
- Reset: all outputs 0; all channel FSMs in IDLE; capture registers 0.
- Channel FSM states: IDLE, STALL, TIMEOUT.
  - IDLE:
    - valid & ready: beat_count+1, stay.
    - valid & !ready: capture tdata/tuser, stall_cnt=1, go to STALL.
    - !valid: stay.
  - STALL:
    - !valid: valid-drop event, go to IDLE.
    - valid & payload != capture: payload-change event; re-capture the new payload.
    - valid & ready: beat_count+1, update stall_max with stall_cnt, go to IDLE.
    - valid & !ready: stall_cnt+1. When stall_cnt reaches MAX_STALL: timeout event, go to TIMEOUT.
  - TIMEOUT: same valid-drop and payload checks as STALL. stall_cnt holds at MAX_STALL. Exit to IDLE on ready (counts a beat) or on valid drop.
- Latency: flags and counters update on the edge after the offending sample (1 cycle).
- Multiple events in one cycle (e.g. payload change plus timeout): each sets its flag; err_count increments by the number of events, saturating at 2^CNT_W-1.
- Counters saturate at all-ones and never wrap.
- clear and a new event in the same cycle: the event wins. The flag is set and the counter reads the event count, not 0. FSMs and capture registers are not affected by clear.
- Reset mid-stall: FSM returns to IDLE; no event is logged.
- err_any is combinational from the registered sticky flags.

Optional Feature:
- Macro: AXIS_PROTOCOL_MONITOR_SVA_EN.
- Defined: the module additionally contains concurrent assertions, each `disable iff (!res_n_hmc)`, that fire in simulation on every event type per channel. Also included: an assertion that err_count never decrements except on clear, and a cover property for each FSM state.
- Undefined: no assertions and no `assert`/`cover` constructs; RTL is purely synthesizable. Flag and counter behaviour is identical in both builds.

Decomposition:
- Package axis_mon_pkg:
  - enum ch_state_t {IDLE, STALL, TIMEOUT}.
  - event-bit localparams EV_DROP, EV_PAYLOAD, EV_TIMEOUT.
  - saturating-increment function sat_add(cnt, inc, width).
- Sub-module axis_mon_channel: one channel's FSM, capture registers, counters and flags.
- Top-level: generate loop over NUM_CH, port slicing, err_any reduction.

Test Plan:
- Ch0 valid & ready for 10 cycles with no stalls -> beat_count[0]=10, all flags 0, stall_max[0]=0.
- Ch1 stalls 5 cycles with constant payload, then ready -> beat_count[1]=1, stall_max[1]=5, no errors.
- Ch0 TDATA bit 0 toggles on the 3rd stall cycle -> err_payload_change[0]=1 one cycle later, err_count[0]=1, err_any=1; ch1 unaffected.
- MAX_STALL=8, ch0 stalls 8 cycles then valid drops -> err_timeout[0]=1, then err_valid_drop[0]=1, err_count[0]=2.
- CNT_W=4, 20 beats on ch1 -> beat_count[1]=15 (saturated). Then clear in the same cycle as a ch1 valid drop -> err_valid_drop[1]=1, err_count[1]=1.
- res_n_hmc pulsed low during a ch0 stall -> all outputs 0 immediately; after release a fresh 3-cycle stall gives stall_max[0]=3 and no errors.

Source files
------------

// File: rtl/axis_mon_pkg.sv
// Shared types and helpers for the AXI4-Stream protocol monitor.
// Assertions are enabled by defining AXIS_PROTOCOL_MONITOR_SVA_EN.
package axis_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        TIMEOUT = 2'd2
    } ch_state_t;

    localparam int EV_DROP    = 0;
    localparam int EV_PAYLOAD = 1;
    localparam int EV_TIMEOUT = 2;
    localparam int EV_W       = 3;

    // Adds inc to cnt and clamps at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [1:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, cnt} + {31'd0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/axis_mon_channel.sv
// One monitored AXI4-Stream channel: stall FSM, payload capture, flags and counters.
// Defining AXIS_PROTOCOL_MONITOR_SVA_EN adds event assertions and state covers.
module axis_mon_channel
    import axis_mon_pkg::*;
#(
    parameter int DWIDTH    = 512,
    parameter int UWIDTH    = 64,
    parameter int MAX_STALL = 1023,
    parameter int CNT_W     = 16,
    parameter int STALL_W   = $clog2(MAX_STALL + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               ready,
    input  logic [DWIDTH-1:0]  data,
    input  logic [UWIDTH-1:0]  user,
    input  logic               clear,
    output logic               err_drop,
    output logic               err_payload,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   beat_count,
    output logic [STALL_W-1:0] stall_max
);

    ch_state_t                  state_q, state_d;
    logic [DWIDTH+UWIDTH-1:0]   cap_q, cap_d;
    logic [DWIDTH+UWIDTH-1:0]   payload;
    logic [STALL_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [EV_W-1:0]            ev;
    logic [1:0]                 ev_n;
    logic                       beat;
    logic                       smax_upd;

    assign payload = {data, user};
    assign ev_n    = 2'($countones(ev));

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        stall_cnt_d = stall_cnt_q;
        ev          = '0;
        beat        = 1'b0;
        smax_upd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (ready) begin
                        beat = 1'b1;
                    end else begin
                        cap_d       = payload;
                        stall_cnt_d = STALL_W'(1);
                        state_d     = STALL;
                    end
                end
            end
            STALL, TIMEOUT: begin
                if (!valid) begin
                    ev[EV_DROP] = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (payload != cap_q) begin
                        ev[EV_PAYLOAD] = 1'b1;
                        cap_d          = payload;
                    end
                    if (ready) begin
                        beat     = 1'b1;
                        smax_upd = 1'b1;
                        state_d  = IDLE;
                    end else if (state_q == STALL) begin
                        // TIMEOUT holds the count at MAX_STALL; only STALL advances it.
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                        if (stall_cnt_d == STALL_W'(MAX_STALL)) begin
                            ev[EV_TIMEOUT] = 1'b1;
                            state_d        = TIMEOUT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A clear coinciding with an event keeps the event: clear zeroes first, then the event adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop    <= 1'b0;
            err_payload <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
            beat_count  <= '0;
            stall_max   <= '0;
        end else begin
            err_drop    <= (err_drop    & ~clear) | ev[EV_DROP];
            err_payload <= (err_payload & ~clear) | ev[EV_PAYLOAD];
            err_timeout <= (err_timeout & ~clear) | ev[EV_TIMEOUT];
            err_count   <= CNT_W'(sat_add(clear ? 32'd0 : 32'(err_count), ev_n, CNT_W));
            beat_count  <= CNT_W'(sat_add(clear ? 32'd0 : 32'(beat_count), {1'b0, beat}, CNT_W));
            if (clear) begin
                stall_max <= smax_upd ? stall_cnt_q : '0;
            end else if (smax_upd && (stall_cnt_q > stall_max)) begin
                stall_max <= stall_cnt_q;
            end
        end
    end

`ifdef AXIS_PROTOCOL_MONITOR_SVA_EN
    a_valid_drop: assert property (@(posedge clk) disable iff (!rst_n) !ev[EV_DROP]);
    a_payload_change: assert property (@(posedge clk) disable iff (!rst_n) !ev[EV_PAYLOAD]);
    a_stall_timeout: assert property (@(posedge clk) disable iff (!rst_n) !ev[EV_TIMEOUT]);
    a_err_count_mono: assert property (@(posedge clk) disable iff (!rst_n)
                                       !clear |=> (err_count >= $past(err_count)));
    c_idle: cover property (@(posedge clk) disable iff (!rst_n) state_q == IDLE);
    c_stall: cover property (@(posedge clk) disable iff (!rst_n) state_q == STALL);
    c_timeout: cover property (@(posedge clk) disable iff (!rst_n) state_q == TIMEOUT);
`else
`endif

endmodule

// File: rtl/axis_protocol_monitor.sv
// Passive multi-channel AXI4-Stream protocol monitor; one axis_mon_channel per stream.
// Defining AXIS_PROTOCOL_MONITOR_SVA_EN enables per-channel assertions and covers.
module axis_protocol_monitor
    import axis_mon_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DWIDTH    = 512,
    parameter int UWIDTH    = 64,
    parameter int MAX_STALL = 1023,
    parameter int CNT_W     = 16,
    parameter int STALL_W   = $clog2(MAX_STALL + 1)
) (
    input  logic                      clk_hmc,
    input  logic                      res_n_hmc,
    input  logic [NUM_CH-1:0]         tvalid,
    input  logic [NUM_CH-1:0]         tready,
    input  logic [NUM_CH*DWIDTH-1:0]  tdata,
    input  logic [NUM_CH*UWIDTH-1:0]  tuser,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         err_valid_drop,
    output logic [NUM_CH-1:0]         err_payload_change,
    output logic [NUM_CH-1:0]         err_timeout,
    output logic                      err_any,
    output logic [NUM_CH*CNT_W-1:0]   err_count,
    output logic [NUM_CH*CNT_W-1:0]   beat_count,
    output logic [NUM_CH*STALL_W-1:0] stall_max
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        axis_mon_channel #(
            .DWIDTH    (DWIDTH),
            .UWIDTH    (UWIDTH),
            .MAX_STALL (MAX_STALL),
            .CNT_W     (CNT_W),
            .STALL_W   (STALL_W)
        ) u_ch (
            .clk         (clk_hmc),
            .rst_n       (res_n_hmc),
            .valid       (tvalid[c]),
            .ready       (tready[c]),
            .data        (tdata[c*DWIDTH +: DWIDTH]),
            .user        (tuser[c*UWIDTH +: UWIDTH]),
            .clear       (clear),
            .err_drop    (err_valid_drop[c]),
            .err_payload (err_payload_change[c]),
            .err_timeout (err_timeout[c]),
            .err_count   (err_count[c*CNT_W +: CNT_W]),
            .beat_count  (beat_count[c*CNT_W +: CNT_W]),
            .stall_max   (stall_max[c*STALL_W +: STALL_W])
        );
    end

    assign err_any = |{err_valid_drop, err_payload_change, err_timeout};

endmodule

// File: tb/tb_axis_protocol_monitor.sv
// Directed bench for axis_protocol_monitor with a rule-level reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_axis_protocol_monitor;

    localparam int NUM_CH    = 2;
    localparam int DW        = 16;
    localparam int UW        = 8;
    localparam int MAX_STALL = 8;
    localparam int CNT_W     = 4;
    localparam int STALL_W   = $clog2(MAX_STALL + 1);
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic                      clk_hmc;
    logic                      res_n_hmc;
    logic [NUM_CH-1:0]         tvalid;
    logic [NUM_CH-1:0]         tready;
    logic [NUM_CH*DW-1:0]      tdata;
    logic [NUM_CH*UW-1:0]      tuser;
    logic                      clear;
    logic [NUM_CH-1:0]         err_valid_drop;
    logic [NUM_CH-1:0]         err_payload_change;
    logic [NUM_CH-1:0]         err_timeout;
    logic                      err_any;
    logic [NUM_CH*CNT_W-1:0]   err_count;
    logic [NUM_CH*CNT_W-1:0]   beat_count;
    logic [NUM_CH*STALL_W-1:0] stall_max;

    int checks = 0;
    int errors = 0;

    axis_protocol_monitor #(
        .NUM_CH    (NUM_CH),
        .DWIDTH    (DW),
        .UWIDTH    (UW),
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_hmc            (clk_hmc),
        .res_n_hmc          (res_n_hmc),
        .tvalid             (tvalid),
        .tready             (tready),
        .tdata              (tdata),
        .tuser              (tuser),
        .clear              (clear),
        .err_valid_drop     (err_valid_drop),
        .err_payload_change (err_payload_change),
        .err_timeout        (err_timeout),
        .err_any            (err_any),
        .err_count          (err_count),
        .beat_count         (beat_count),
        .stall_max          (stall_max)
    );

    // clock / reset
    initial begin
        clk_hmc = 1'b0;
        forever #5 clk_hmc = ~clk_hmc;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: a stall is a run of valid&!ready samples; events follow the rules directly
    bit                 m_in_stall [NUM_CH];
    int                 m_run      [NUM_CH];
    logic [DW+UW-1:0]   m_held     [NUM_CH];
    bit                 m_drop     [NUM_CH];
    bit                 m_pay      [NUM_CH];
    bit                 m_tmo      [NUM_CH];
    int                 m_err      [NUM_CH];
    int                 m_beat     [NUM_CH];
    int                 m_smax     [NUM_CH];

    always @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_in_stall[c] = 0; m_run[c] = 0; m_held[c] = '0;
                m_drop[c] = 0; m_pay[c] = 0; m_tmo[c] = 0;
                m_err[c] = 0; m_beat[c] = 0; m_smax[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic             v, r;
                logic [DW+UW-1:0] p;
                int               n;
                v = tvalid[c];
                r = tready[c];
                p = {tdata[c*DW +: DW], tuser[c*UW +: UW]};
                n = 0;
                if (clear) begin
                    m_drop[c] = 0; m_pay[c] = 0; m_tmo[c] = 0;
                    m_err[c] = 0; m_beat[c] = 0; m_smax[c] = 0;
                end
                if (m_in_stall[c]) begin
                    if (!v) begin
                        m_drop[c] = 1; n++; m_in_stall[c] = 0;
                    end else begin
                        if (p != m_held[c]) begin
                            m_pay[c] = 1; n++; m_held[c] = p;
                        end
                        if (r) begin
                            m_beat[c] = (m_beat[c] < CMAX) ? m_beat[c] + 1 : CMAX;
                            if (m_run[c] > m_smax[c]) m_smax[c] = m_run[c];
                            m_in_stall[c] = 0;
                        end else if (m_run[c] < MAX_STALL) begin
                            m_run[c]++;
                            if (m_run[c] == MAX_STALL) begin
                                m_tmo[c] = 1; n++;
                            end
                        end
                    end
                end else if (v) begin
                    if (r) begin
                        m_beat[c] = (m_beat[c] < CMAX) ? m_beat[c] + 1 : CMAX;
                    end else begin
                        m_in_stall[c] = 1; m_run[c] = 1; m_held[c] = p;
                    end
                end
                m_err[c] = (m_err[c] + n > CMAX) ? CMAX : m_err[c] + n;
            end
        end
    end

    // per-cycle comparison, away from the active edge
    always @(negedge clk_hmc) begin
        if (res_n_hmc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                check($sformatf("cyc ch%0d err_valid_drop", c), int'(err_valid_drop[c]), int'(m_drop[c]));
                check($sformatf("cyc ch%0d err_payload_change", c), int'(err_payload_change[c]), int'(m_pay[c]));
                check($sformatf("cyc ch%0d err_timeout", c), int'(err_timeout[c]), int'(m_tmo[c]));
                check($sformatf("cyc ch%0d err_count", c), int'(err_count[c*CNT_W +: CNT_W]), m_err[c]);
                check($sformatf("cyc ch%0d beat_count", c), int'(beat_count[c*CNT_W +: CNT_W]), m_beat[c]);
                check($sformatf("cyc ch%0d stall_max", c), int'(stall_max[c*STALL_W +: STALL_W]), m_smax[c]);
            end
            check("cyc err_any", int'(err_any),
                  int'(m_drop[0] | m_pay[0] | m_tmo[0] | m_drop[1] | m_pay[1] | m_tmo[1]));
        end
    end

    // driver tasks
    task automatic set_ch(input int c, input logic v, input logic r,
                          input logic [DW-1:0] d, input logic [UW-1:0] u);
        tvalid[c]           = v;
        tready[c]           = r;
        tdata[c*DW +: DW]   = d;
        tuser[c*UW +: UW]   = u;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_hmc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " err_valid_drop"}, int'(err_valid_drop), 0);
        check({tag, " err_payload_change"}, int'(err_payload_change), 0);
        check({tag, " err_timeout"}, int'(err_timeout), 0);
        check({tag, " err_any"}, int'(err_any), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " beat_count"}, int'(beat_count), 0);
        check({tag, " stall_max"}, int'(stall_max), 0);
    endtask

    initial begin
        res_n_hmc = 1'b0;
        tvalid = '0; tready = '0; tdata = '0; tuser = '0; clear = 1'b0;
        cycles(2);
        check_all_zero("reset");
        res_n_hmc = 1'b1;
        cycles(1);

        // 10 back-to-back beats on ch0
        set_ch(0, 1'b1, 1'b1, 16'h1234, 8'h56);
        cycles(10);
        set_ch(0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("t1 beat_count0", int'(beat_count[3:0]), 10);
        check("t1 err_any", int'(err_any), 0);
        check("t1 stall_max0", int'(stall_max[3:0]), 0);

        // ch1 five stall cycles with constant payload, then accept
        set_ch(1, 1'b1, 1'b0, 16'hA5A5, 8'h3C);
        cycles(5);
        tready[1] = 1'b1;
        cycles(1);
        set_ch(1, 1'b0, 1'b0, 16'h0, 8'h0);
        check("t2 beat_count1", int'(beat_count[7:4]), 1);
        check("t2 stall_max1", int'(stall_max[7:4]), 5);
        check("t2 err_count1", int'(err_count[7:4]), 0);

        // ch0 payload bit 0 flips on the third stall cycle
        set_ch(0, 1'b1, 1'b0, 16'hBEEE, 8'h11);
        cycles(2);
        tdata[0] = 1'b1;
        cycles(1);
        check("t3 err_payload_change0", int'(err_payload_change[0]), 1);
        check("t3 err_count0", int'(err_count[3:0]), 1);
        check("t3 err_any", int'(err_any), 1);
        check("t3 err_count1", int'(err_count[7:4]), 0);
        tready[0] = 1'b1;
        cycles(1);
        set_ch(0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("t3 beat_count0", int'(beat_count[3:0]), 11);
        check("t3 stall_max0", int'(stall_max[3:0]), 3);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check_all_zero("clear");

        // ch0 reaches MAX_STALL, then drops valid
        set_ch(0, 1'b1, 1'b0, 16'h0F0F, 8'h77);
        cycles(8);
        check("t4 err_timeout0", int'(err_timeout[0]), 1);
        check("t4 err_count0 after timeout", int'(err_count[3:0]), 1);
        check("t4 err_valid_drop0 before drop", int'(err_valid_drop[0]), 0);
        set_ch(0, 1'b0, 1'b0, 16'h0F0F, 8'h77);
        cycles(1);
        check("t4 err_valid_drop0", int'(err_valid_drop[0]), 1);
        check("t4 err_count0", int'(err_count[3:0]), 2);

        // ch1: payload change in the timeout cycle (two events), then accept from TIMEOUT
        set_ch(1, 1'b1, 1'b0, 16'h1111, 8'h22);
        cycles(7);
        tuser[15:8] = 8'h23;
        cycles(1);
        check("t4b err_count1 double event", int'(err_count[7:4]), 2);
        check("t4b err_timeout1", int'(err_timeout[1]), 1);
        check("t4b err_payload_change1", int'(err_payload_change[1]), 1);
        cycles(2);
        tready[1] = 1'b1;
        cycles(1);
        set_ch(1, 1'b0, 1'b0, 16'h0, 8'h0);
        check("t4b stall_max1", int'(stall_max[7:4]), 8);
        check("t4b beat_count1", int'(beat_count[7:4]), 1);
        check("t4b err_count1", int'(err_count[7:4]), 2);

        // ch1 beat counter saturates, then clear collides with a valid drop
        set_ch(1, 1'b1, 1'b1, 16'h2222, 8'h33);
        cycles(20);
        check("t5 beat_count1 saturated", int'(beat_count[7:4]), 15);
        tready[1] = 1'b0;
        cycles(1);
        tvalid[1] = 1'b0;
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("t5 err_valid_drop1", int'(err_valid_drop[1]), 1);
        check("t5 err_count1", int'(err_count[7:4]), 1);
        check("t5 beat_count1", int'(beat_count[7:4]), 0);
        check("t5 err_count0", int'(err_count[3:0]), 0);
        check("t5 err_timeout", int'(err_timeout), 0);

        // reset during a ch0 stall, then a fresh 3-cycle stall
        set_ch(0, 1'b1, 1'b0, 16'h4444, 8'h55);
        cycles(2);
        #2 res_n_hmc = 1'b0;
        #1 check_all_zero("midreset");
        set_ch(0, 1'b0, 1'b0, 16'h0, 8'h0);
        cycles(1);
        res_n_hmc = 1'b1;
        set_ch(0, 1'b1, 1'b0, 16'h6666, 8'h77);
        cycles(3);
        tready[0] = 1'b1;
        cycles(1);
        set_ch(0, 1'b0, 1'b0, 16'h0, 8'h0);
        check("t6 stall_max0", int'(stall_max[3:0]), 3);
        check("t6 beat_count0", int'(beat_count[3:0]), 1);
        check("t6 err_count0", int'(err_count[3:0]), 0);
        check("t6 err_any", int'(err_any), 0);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
